// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline definitions: opcode constants, shadow-entry layout and the
// opcode classification helper used by the hazard controller.
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam int unsigned FWD_REGFILE = 0;

    // Register addresses are zero-extended into this field, so REG_AW must not exceed it.
    localparam int unsigned SHADOW_AW = 8;

    typedef struct packed {
        logic                 valid;
        logic [SHADOW_AW-1:0] rd;
        logic                 wr;
        logic                 is_load;
    } shadow_entry_t;

    typedef struct packed {
        logic writes_rd;
        logic is_load;
        logic uses_rs1;
        logic uses_rs2;
    } op_class_t;

    function automatic op_class_t classify(input logic [6:0] op);
        op_class_t c;
        c.writes_rd = 1'b0;
        c.is_load   = 1'b0;
        c.uses_rs1  = 1'b1;
        c.uses_rs2  = 1'b0;
        case (op)
            OP_R: begin
                c.writes_rd = 1'b1;
                c.uses_rs2  = 1'b1;
            end
            OP_IMM:   c.writes_rd = 1'b1;
            OP_LOAD: begin
                c.writes_rd = 1'b1;
                c.is_load   = 1'b1;
            end
            OP_LUI, OP_AUIPC, OP_JAL: begin
                c.writes_rd = 1'b1;
                c.uses_rs1  = 1'b0;
            end
            OP_JALR:  c.writes_rd = 1'b1;
            OP_STORE, OP_BRANCH: c.uses_rs2 = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/opcode_class.sv
// Combinational opcode decoder: which operands an instruction reads, whether it
// writes a register, and whether it is a load.
module opcode_class
    import riscv_pkg::*;
(
    input  logic [6:0] opcode_i,
    output logic       writes_rd_o,
    output logic       is_load_o,
    output logic       uses_rs1_o,
    output logic       uses_rs2_o
);

    op_class_t cls;

    always_comb begin
        cls         = classify(opcode_i);
        writes_rd_o = cls.writes_rd;
        is_load_o   = cls.is_load;
        uses_rs1_o  = cls.uses_rs1;
        uses_rs2_o  = cls.uses_rs2;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Stateful pipeline hazard controller: shadow pipeline of in-flight destinations driving
// forwarding selects, load-use interlocks, redirect flushes and memory-wait freezes.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned REG_AW       = 5,
    parameter int unsigned DEPTH        = 3,
    parameter int unsigned LOAD_FWD_MIN = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       id_valid,
    input  logic [6:0]                 id_opcode,
    input  logic [REG_AW-1:0]          id_rd,
    input  logic [REG_AW-1:0]          id_rs1,
    input  logic [REG_AW-1:0]          id_rs2,
    input  logic                       ex_redirect,
    input  logic                       mem_stall,
    output logic                       stall_if_id,
    output logic                       bubble_id_ex,
    output logic                       flush_if_id,
    output logic [$clog2(DEPTH+1)-1:0] fwd_sel_rs1,
    output logic [$clog2(DEPTH+1)-1:0] fwd_sel_rs2,
    output logic                       ex_fwd_valid
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]                perf_stall_cnt,
    output logic [31:0]                perf_flush_cnt
`endif
);

    localparam int unsigned SELW = $clog2(DEPTH + 1);

    logic id_writes_rd;
    logic id_is_load;
    logic id_uses_rs1;
    logic id_uses_rs2;

    opcode_class u_opcode_class (
        .opcode_i    (id_opcode),
        .writes_rd_o (id_writes_rd),
        .is_load_o   (id_is_load),
        .uses_rs1_o  (id_uses_rs1),
        .uses_rs2_o  (id_uses_rs2)
    );

    shadow_entry_t   shadow_q [DEPTH];
    shadow_entry_t   entry_d;
    logic [SELW-1:0] fwd_rs1_q;
    logic [SELW-1:0] fwd_rs2_q;
    logic [SELW-1:0] fwd_rs1_d;
    logic [SELW-1:0] fwd_rs2_d;
    logic            ex_valid_q;

    logic                 chk_rs1;
    logic                 chk_rs2;
    logic [SHADOW_AW-1:0] rs1_ext;
    logic [SHADOW_AW-1:0] rs2_ext;
    logic                 ld_rs1;
    logic                 ld_rs2;
    logic                 load_use;
    logic                 kill;
    logic                 stall_c;
    logic                 bubble_c;
    logic                 flush_c;

    assign chk_rs1 = id_valid && id_uses_rs1 && (id_rs1 != '0);
    assign chk_rs2 = id_valid && id_uses_rs2 && (id_rs2 != '0);
    assign rs1_ext = SHADOW_AW'(id_rs1);
    assign rs2_ext = SHADOW_AW'(id_rs2);

    // Scanning oldest-to-youngest lets the youngest producer overwrite older matches.
    always_comb begin
        fwd_rs1_d = '0;
        fwd_rs2_d = '0;
        ld_rs1    = 1'b0;
        ld_rs2    = 1'b0;
        for (int unsigned k = DEPTH; k > 0; k--) begin
            if (chk_rs1 && shadow_q[k-1].valid && shadow_q[k-1].wr &&
                shadow_q[k-1].rd == rs1_ext) begin
                fwd_rs1_d = SELW'(k);
                ld_rs1    = shadow_q[k-1].is_load;
            end
            if (chk_rs2 && shadow_q[k-1].valid && shadow_q[k-1].wr &&
                shadow_q[k-1].rd == rs2_ext) begin
                fwd_rs2_d = SELW'(k);
                ld_rs2    = shadow_q[k-1].is_load;
            end
        end
    end

    assign load_use = (ld_rs1 && (32'(fwd_rs1_d) < LOAD_FWD_MIN)) ||
                      (ld_rs2 && (32'(fwd_rs2_d) < LOAD_FWD_MIN));

    // mem_stall outranks everything; a held redirect is acted on once the freeze lifts.
    always_comb begin
        stall_c  = 1'b0;
        bubble_c = 1'b0;
        flush_c  = 1'b0;
        if (!rst_n) begin
            stall_c = 1'b0;
        end else if (mem_stall) begin
            stall_c = 1'b1;
        end else if (ex_redirect) begin
            flush_c  = 1'b1;
            bubble_c = 1'b1;
        end else if (load_use) begin
            stall_c  = 1'b1;
            bubble_c = 1'b1;
        end
    end

    assign kill = bubble_c || ex_redirect || !id_valid;

    always_comb begin
        entry_d = '0;
        if (!kill) begin
            entry_d.valid   = 1'b1;
            entry_d.rd      = SHADOW_AW'(id_rd);
            entry_d.wr      = id_writes_rd && (id_rd != '0);
            entry_d.is_load = id_is_load;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                shadow_q[k] <= '0;
            end
            fwd_rs1_q  <= '0;
            fwd_rs2_q  <= '0;
            ex_valid_q <= 1'b0;
        end else if (!mem_stall) begin
            for (int unsigned k = 1; k < DEPTH; k++) begin
                shadow_q[k] <= shadow_q[k-1];
            end
            shadow_q[0] <= entry_d;
            fwd_rs1_q   <= kill ? '0 : fwd_rs1_d;
            fwd_rs2_q   <= kill ? '0 : fwd_rs2_d;
            ex_valid_q  <= !kill;
        end
    end

    assign stall_if_id  = stall_c;
    assign bubble_id_ex = bubble_c;
    assign flush_if_id  = flush_c;
    assign fwd_sel_rs1  = fwd_rs1_q;
    assign fwd_sel_rs2  = fwd_rs2_q;
    assign ex_fwd_valid = ex_valid_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;
    logic        stall_evt;
    logic        flush_evt;

    assign stall_evt = mem_stall || (load_use && !ex_redirect);
    assign flush_evt = ex_redirect && !mem_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (stall_evt && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (flush_evt && (perf_flush_q != '1)) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl (DEPTH=3, LOAD_FWD_MIN=2); perf counters
// are checked as well when HAZARD_PERF_EN is defined.
module tb_hazard_ctrl;
    import riscv_pkg::*;

    typedef struct packed {
        logic [1:0] s1;
        logic [1:0] s2;
        logic       v;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [6:0] id_opcode;
    logic [4:0] id_rd;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       ex_redirect;
    logic       mem_stall;
    logic       stall_if_id;
    logic       bubble_id_ex;
    logic       flush_if_id;
    logic [1:0] fwd_sel_rs1;
    logic [1:0] fwd_sel_rs2;
    logic       ex_fwd_valid;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    int unsigned n_pass;
    int unsigned n_total;
    exp_t        exp_q[$];

    hazard_ctrl #(
        .REG_AW       (5),
        .DEPTH        (3),
        .LOAD_FWD_MIN (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_opcode    (id_opcode),
        .id_rd        (id_rd),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .ex_redirect  (ex_redirect),
        .mem_stall    (mem_stall),
        .stall_if_id  (stall_if_id),
        .bubble_id_ex (bubble_id_ex),
        .flush_if_id  (flush_if_id),
        .fwd_sel_rs1  (fwd_sel_rs1),
        .fwd_sel_rs2  (fwd_sel_rs2),
        .ex_fwd_valid (ex_fwd_valid)
`ifdef HAZARD_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".stall"},  {31'd0, stall_if_id},  32'd0);
        chk({tag, ".bubble"}, {31'd0, bubble_id_ex}, 32'd0);
        chk({tag, ".flush"},  {31'd0, flush_if_id},  32'd0);
        chk({tag, ".sel1"},   {30'd0, fwd_sel_rs1},  32'd0);
        chk({tag, ".sel2"},   {30'd0, fwd_sel_rs2},  32'd0);
        chk({tag, ".exv"},    {31'd0, ex_fwd_valid}, 32'd0);
    endtask

    // One decode slot: drive on the falling edge, check combinational controls
    // before the rising edge, then check the EX-side selects for this slot after it.
    task automatic step(input string tag, input logic v, input logic [6:0] op,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic rdr, input logic ms,
                        input logic es, input logic eb, input logic ef,
                        input logic [1:0] s1, input logic [1:0] s2, input logic ev);
        exp_t e;
        @(negedge clk);
        id_valid    = v;
        id_opcode   = op;
        id_rd       = rd;
        id_rs1      = rs1;
        id_rs2      = rs2;
        ex_redirect = rdr;
        mem_stall   = ms;
        #2;
        chk({tag, ".stall"},  {31'd0, stall_if_id},  {31'd0, es});
        chk({tag, ".bubble"}, {31'd0, bubble_id_ex}, {31'd0, eb});
        chk({tag, ".flush"},  {31'd0, flush_if_id},  {31'd0, ef});
        exp_q.push_back('{s1: s1, s2: s2, v: ev});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({tag, ".sel1"}, {30'd0, fwd_sel_rs1},  {30'd0, e.s1});
        chk({tag, ".sel2"}, {30'd0, fwd_sel_rs2},  {30'd0, e.s2});
        chk({tag, ".exv"},  {31'd0, ex_fwd_valid}, {31'd0, e.v});
    endtask

    initial begin
        n_pass      = 0;
        n_total     = 0;
        rst_n       = 1'b0;
        id_valid    = 1'b0;
        id_opcode   = '0;
        id_rd       = '0;
        id_rs1      = '0;
        id_rs2      = '0;
        ex_redirect = 1'b0;
        mem_stall   = 1'b0;

        #3;
        chk_all_zero("reset");
`ifdef HAZARD_PERF_EN
        chk("reset.pstall", perf_stall_cnt, 32'd0);
        chk("reset.pflush", perf_flush_cnt, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        //    tag       v  opcode     rd  rs1 rs2 rdr ms  st bb fl  s1 s2 ev
        step("add_x5",  1, OP_R,      5,  1,  2,  0,  0,  0, 0, 0,  0, 0, 1);
        step("fwd_ex",  1, OP_R,      6,  5,  5,  0,  0,  0, 0, 0,  1, 1, 1);
        step("lw_x7",   1, OP_LOAD,   7,  6,  5,  0,  0,  0, 0, 0,  1, 0, 1);
        step("ldu_stl", 1, OP_R,      8,  7,  0,  0,  0,  1, 1, 0,  0, 0, 0);
        step("ldu_go",  1, OP_R,      8,  7,  0,  0,  0,  0, 0, 0,  2, 0, 1);
        step("wr_x0",   1, OP_IMM,    0,  3,  0,  0,  0,  0, 0, 0,  0, 0, 1);
        step("rd_x0",   1, OP_R,      9,  0,  0,  0,  0,  0, 0, 0,  0, 0, 1);
        step("fwd_wb",  1, OP_R,     10,  9,  8,  0,  0,  0, 0, 0,  1, 3, 1);
        step("imm_rs2", 1, OP_IMM,    9,  9, 10,  0,  0,  0, 0, 0,  2, 0, 1);
        step("young",   1, OP_R,     11,  9, 10,  0,  0,  0, 0, 0,  1, 2, 1);
        step("lw_x12",  1, OP_LOAD,  12, 11,  0,  0,  0,  0, 0, 0,  1, 0, 1);
        step("ldu_rdr", 1, OP_R,     13, 12, 12,  1,  0,  0, 1, 1,  0, 0, 0);
        step("nop",     0, OP_R,     13, 12, 12,  0,  0,  0, 0, 0,  0, 0, 0);
        step("ld_far",  1, OP_R,     14, 12, 11,  0,  0,  0, 0, 0,  3, 0, 1);
`ifdef HAZARD_PERF_EN
        chk("pre_ms.pstall", perf_stall_cnt, 32'd1);
        chk("pre_ms.pflush", perf_flush_cnt, 32'd1);
`endif
        step("ms1",     1, OP_R,     15, 14, 14,  0,  1,  1, 0, 0,  3, 0, 1);
        step("ms2",     1, OP_R,     15, 14, 14,  0,  1,  1, 0, 0,  3, 0, 1);
        step("ms3",     1, OP_R,     15, 14, 14,  0,  1,  1, 0, 0,  3, 0, 1);
        step("ms_done", 1, OP_R,     15, 14, 14,  0,  0,  0, 0, 0,  1, 1, 1);
`ifdef HAZARD_PERF_EN
        chk("post_ms.pstall", perf_stall_cnt, 32'd4);
`endif
        step("ms_rdr",  1, OP_R,     16, 15,  0,  1,  1,  1, 0, 0,  1, 1, 1);
        step("rdr_act", 1, OP_R,     16, 15,  0,  1,  0,  0, 1, 1,  0, 0, 0);
`ifdef HAZARD_PERF_EN
        chk("post_rdr.pstall", perf_stall_cnt, 32'd5);
        chk("post_rdr.pflush", perf_flush_cnt, 32'd2);
`endif
        step("lw_x20",  1, OP_LOAD,  20,  0,  0,  0,  0,  0, 0, 0,  0, 0, 1);

        // Load-use stall pending, then asynchronous reset before the next edge.
        @(negedge clk);
        id_valid    = 1'b1;
        id_opcode   = OP_R;
        id_rd       = 5'd21;
        id_rs1      = 5'd20;
        id_rs2      = 5'd0;
        ex_redirect = 1'b0;
        mem_stall   = 1'b0;
        #2;
        chk("pre_rst.stall", {31'd0, stall_if_id}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
`ifdef HAZARD_PERF_EN
        chk("async_rst.pstall", perf_stall_cnt, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step("no_stale", 1, OP_R,    21, 20,  0,  0,  0,  0, 0, 0,  0, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
